// File: rtl/irq_encoder.sv
// rtl/irq_encoder.sv - latching priority encoder for interrupt requests
//
// Captures rising edges on N request lines into a pending register.
// Presents the index of the lowest-numbered unmasked pending source over a
// valid/ack handshake, and clears that pending bit when the grant is acknowledged.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   en        capture enable; rises seen while low are dropped
//   req       request lines (level); a rising edge is a new request
//   mask      1 = source not selectable (still captured)
//   ack       consumer accepts the presented code (ignored when valid=0)
//   clr_lost  clears the sticky lost register
//   data_out  index of the granted source (held after ack; qualify with valid)
//   valid     data_out carries a live grant
//   pending   captured, not-yet-acknowledged requests
//   lost      sticky: an edge arrived while the same bit was already pending

module irq_encoder #(
  parameter int W = 3,
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic         ack,
  input  logic         clr_lost,
  output logic [W-1:0] data_out,
  output logic         valid,
  output logic [N-1:0] pending,
  output logic [N-1:0] lost
);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic [N-1:0] r_req_d;
  logic [N-1:0] r_pending;
  logic [N-1:0] r_lost;
  logic [W-1:0] r_data_out;
  logic         r_valid;

  logic [N-1:0] w_rise;
  logic [N-1:0] w_cap;
  logic [N-1:0] w_clr;
  logic [N-1:0] w_lost_set;
  logic [N-1:0] w_eligible;
  logic [W-1:0] w_enc_idx;
  logic [W-1:0] w_data_next;
  logic         w_valid_next;
  logic         w_ack_grant;

  assign w_rise      = req & ~r_req_d;
  assign w_cap       = en ? w_rise : '0;
  assign w_ack_grant = (r_state == S_GRANT) && ack;
  assign w_clr       = w_ack_grant ? ({{(N-1){1'b0}}, 1'b1} << r_data_out) : '0;
  // A rise on the bit being acknowledged re-arms it rather than counting as lost.
  assign w_lost_set  = w_cap & r_pending & ~w_clr;
  // Selection looks at the registered pending, so a fresh capture is granted
  // one edge after it lands.
  assign w_eligible  = r_pending & ~mask;

  // Lowest set bit wins: scan downward so the last assignment is the lowest index.
  always_comb begin
    w_enc_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_enc_idx = W'(i);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_data_next  = r_data_out;
    w_valid_next = r_valid;
    case (r_state)
      S_IDLE: begin
        w_valid_next = 1'b0;
        if (|w_eligible) begin
          w_data_next  = w_enc_idx;
          w_valid_next = 1'b1;
          w_state_next = S_GRANT;
        end
      end
      S_GRANT: begin
        if (ack) begin
          w_valid_next = 1'b0;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_valid_next = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // All ones so that lines already high when reset releases are not seen as edges.
      r_req_d    <= '1;
      r_pending  <= '0;
      r_lost     <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_req_d    <= req;
      r_pending  <= (r_pending & ~w_clr) | w_cap;
      r_lost     <= (clr_lost ? '0 : r_lost) | w_lost_set;
      r_data_out <= w_data_next;
      r_valid    <= w_valid_next;
    end
  end

  assign data_out = r_data_out;
  assign valid    = r_valid;
  assign pending  = r_pending;
  assign lost     = r_lost;

endmodule

// File: tb/tb_irq_encoder.sv
// tb/tb_irq_encoder.sv - scoreboard bench for irq_encoder

module tb_irq_encoder;

  localparam int W = 3;
  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [N-1:0] req;
  logic [N-1:0] mask;
  logic         ack;
  logic         clr_lost;
  logic [W-1:0] data_out;
  logic         valid;
  logic [N-1:0] pending;
  logic [N-1:0] lost;

  int n_checks;
  int n_errors;
  int exp_q[$];

  irq_encoder #(.W(W), .N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .req      (req),
    .mask     (mask),
    .ack      (ack),
    .clr_lost (clr_lost),
    .data_out (data_out),
    .valid    (valid),
    .pending  (pending),
    .lost     (lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_grant(input string tag);
    int e;
    check_eq({tag, "_valid"}, valid, 1);
    check_eq({tag, "_sb_nonempty"}, exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_eq({tag, "_code"}, data_out, e);
    end
  endtask

  task automatic wait_grant(input string tag);
    int cyc;
    cyc = 0;
    while (!valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check_grant(tag);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    logic [N-1:0] pend_seq [3];
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    req      = '0;
    mask     = '0;
    ack      = 1'b0;
    clr_lost = 1'b0;
    tick();
    tick();
    check_eq("rst_pending", pending, 0);
    check_eq("rst_lost", lost, 0);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_data", data_out, 0);
    rst_n = 1'b1;
    en    = 1'b1;
    tick();

    // 1: single request, exact latency
    req[5] = 1'b1;
    exp_q.push_back(5);
    tick();
    check_eq("t1_pending", pending, 8'h20);
    check_eq("t1_valid_early", valid, 0);
    tick();
    check_grant("t1");
    do_ack();
    check_eq("t1_valid_after_ack", valid, 0);
    check_eq("t1_pending_after_ack", pending, 0);
    check_eq("t1_data_held", data_out, 5);
    req = '0;
    tick();

    // 2: simultaneous rises, priority order with idle gaps
    req = 8'h54;
    exp_q.push_back(2);
    exp_q.push_back(4);
    exp_q.push_back(6);
    pend_seq[0] = 8'h50;
    pend_seq[1] = 8'h40;
    pend_seq[2] = 8'h00;
    tick();
    check_eq("t2_pending", pending, 8'h54);
    for (int g = 0; g < 3; g++) begin
      tick();
      check_grant("t2");
      do_ack();
      check_eq("t2_idle_gap", valid, 0);
      check_eq("t2_pending_step", pending, pend_seq[g]);
    end
    req = '0;
    tick();

    // 3: masked source retained, granted when unmasked
    mask = 8'h01;
    req  = 8'h09;
    exp_q.push_back(3);
    tick();
    check_eq("t3_pending", pending, 8'h09);
    tick();
    check_grant("t3a");
    do_ack();
    check_eq("t3_pending_masked", pending, 8'h01);
    tick();
    check_eq("t3_masked_no_grant", valid, 0);
    mask = '0;
    exp_q.push_back(0);
    tick();
    check_grant("t3b");
    do_ack();
    check_eq("t3_pending_clear", pending, 0);
    req = '0;
    tick();

    // 4: lost flag on re-rise while pending, then clr_lost
    req = 8'h02;
    exp_q.push_back(1);
    tick();
    req = 8'h00;
    tick();
    req = 8'h02;
    tick();
    check_eq("t4_lost", lost, 8'h02);
    check_eq("t4_pending", pending, 8'h02);
    clr_lost = 1'b1;
    tick();
    clr_lost = 1'b0;
    check_eq("t4_lost_cleared", lost, 0);
    wait_grant("t4");
    do_ack();
    check_eq("t4_pending_clear", pending, 0);
    req = '0;
    tick();

    // 5: rise coinciding with the clearing ack; then en gating
    req = 8'h08;
    exp_q.push_back(3);
    tick();
    tick();
    check_grant("t5a");
    req = 8'h00;
    tick();
    check_eq("t5_grant_held", valid, 1);
    req = 8'h08;
    exp_q.push_back(3);
    do_ack();
    check_eq("t5_set_wins_pending", pending, 8'h08);
    check_eq("t5_set_wins_lost", lost, 0);
    tick();
    check_grant("t5b");
    do_ack();
    check_eq("t5_pending_clear", pending, 0);
    en  = 1'b0;
    req = 8'h88;
    tick();
    tick();
    check_eq("t5_en_gated_pending", pending, 0);
    check_eq("t5_en_gated_valid", valid, 0);
    en  = 1'b1;
    req = '0;
    tick();

    // 6: reset during a grant, request held across release
    req = 8'h10;
    exp_q.push_back(4);
    tick();
    tick();
    check_grant("t6");
    req = 8'h00;
    tick();
    req = 8'h10;
    tick();
    check_eq("t6_lost_before_rst", lost, 8'h10);
    rst_n = 1'b0;
    tick();
    check_eq("t6_rst_valid", valid, 0);
    check_eq("t6_rst_pending", pending, 0);
    check_eq("t6_rst_lost", lost, 0);
    rst_n = 1'b1;
    tick();
    tick();
    check_eq("t6_no_capture_pending", pending, 0);
    check_eq("t6_no_capture_valid", valid, 0);

    check_eq("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
